// File: rtl/row_stream_pkg.sv
// row_stream_pkg -- shared types and constants for the row_stream UART frame
// transmitter.
//   tx_state_t : frame FSM states (SEND_CSUM exists only when the
//                ROW_STREAM_CHECKSUM_EN macro is defined)
//   BITS_8N1   : serial bits per byte (start + 8 data + stop)
//   CSUM_W     : checksum accumulator width
package row_stream_pkg;

  localparam int BITS_8N1 = 10;
  localparam int CSUM_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEND_PREFIX,
    SEND_DATA,
`ifdef ROW_STREAM_CHECKSUM_EN
    SEND_CSUM,
`endif
    GAP
  } tx_state_t;

endpackage

// File: rtl/row_stream_if.sv
// row_stream_if -- control/status bundle of row_stream_tx.
//   data_in    : payload, byte 0 in the top byte
//   start      : one-cycle frame request
//   continuous : repeat the frame after each gap
//   tx_out     : 8N1 serial line, idle high
//   busy       : frame (or inter-frame gap) in progress
//   done       : one-cycle pulse at frame end
// master = requester side, slave = transmitter side.
interface row_stream_if #(
  parameter int DATA_WIDTH = 1024
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  start;
  logic                  continuous;
  logic                  tx_out;
  logic                  busy;
  logic                  done;

  modport master (output data_in, start, continuous, input tx_out, busy, done);
  modport slave  (input data_in, start, continuous, output tx_out, busy, done);
endinterface

// File: rtl/row_stream_uart_tx.sv
// row_stream_uart_tx -- 8N1 byte serialiser.
//   clk_in, reset : clock, synchronous active-high reset
//   byte_in/valid : byte offered for transmission
//   ready         : high when idle or in the final cycle of a stop bit, so a
//                   byte accepted then starts with no idle gap
//   tx            : registered serial line, idle high
// The start bit goes on the line in the cycle right after the accept edge.
module row_stream_uart_tx
  import row_stream_pkg::*;
#(
  parameter int TICKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int TW = $clog2(TICKS_PER_BIT);

  logic          active;
  logic [3:0]    bit_idx;   // 0 = start bit, 9 = stop bit
  logic [TW-1:0] tick;
  logic [8:0]    sr;        // remaining bits, next one in [0]
  logic          bit_end;

  assign bit_end = (tick == TW'(TICKS_PER_BIT - 1));
  assign ready   = !active || (bit_end && bit_idx == 4'(BITS_8N1 - 1));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      active  <= 1'b0;
      bit_idx <= '0;
      tick    <= '0;
      sr      <= '0;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      active  <= 1'b1;
      bit_idx <= '0;
      tick    <= '0;
      sr      <= {1'b1, byte_in};
      tx      <= 1'b0;
    end else if (active) begin
      if (bit_end) begin
        tick <= '0;
        if (bit_idx == 4'(BITS_8N1 - 1)) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= sr[0];
          sr      <= {1'b0, sr[8:1]};
        end
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end
endmodule

// File: rtl/row_stream_tx.sv
// row_stream_tx -- sends PREFIX_BYTE, then the payload bytes (MSB byte
// first), then optionally a mod-256 checksum byte, as back-to-back 8N1 UART
// characters. In continuous mode the frame repeats after DIVIDER_TICKS idle
// cycles, relatching data_in each time.
//   clk_in : clock
//   reset  : synchronous, active-high
//   bus    : row_stream_if.slave (data_in/start/continuous in,
//            tx_out/busy/done out)
// Optional feature: define ROW_STREAM_CHECKSUM_EN to append the checksum.
module row_stream_tx
  import row_stream_pkg::*;
#(
  parameter int         DATA_WIDTH         = 1024,
  parameter logic [7:0] PREFIX_BYTE        = 8'h4C,
  parameter int         UART_TICKS_PER_BIT = 16,
  parameter int         DIVIDER_TICKS      = 1000
) (
  input  logic        clk_in,
  input  logic        reset,
  row_stream_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int IDXW = $clog2(NB) + 1;
  localparam int GW   = $clog2(DIVIDER_TICKS + 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shadow;
  logic [IDXW-1:0]       idx;       // payload byte currently on the line
  logic [GW-1:0]         gap_cnt;
  logic                  busy_r;
  logic                  done_r;
`ifdef ROW_STREAM_CHECKSUM_EN
  logic [CSUM_W-1:0]     csum;
`endif

  logic                  tx_ready;
  logic                  tx_line;
  logic                  load;       // hand a byte to the serialiser this edge
  logic [7:0]            load_byte;
  logic                  frame_end;  // last stop bit ends this edge
  logic [IDXW-1:0]       sel_idx;
  logic [DATA_WIDTH-1:0] shifted;
  logic [7:0]            pay_byte;
  logic                  idx_last;
  logic                  gap_last;

  // The next payload byte is byte 0 while the prefix is on the line,
  // otherwise the one after the byte being sent.
  assign sel_idx  = (state == SEND_PREFIX) ? '0 : idx + 1'b1;
  assign shifted  = shadow << (8 * sel_idx);
  assign pay_byte = shifted[DATA_WIDTH-1 -: 8];
  assign idx_last = (idx == IDXW'(NB - 1));
  assign gap_last = (gap_cnt == GW'(DIVIDER_TICKS - 1));

  always_comb begin
    load      = 1'b0;
    load_byte = PREFIX_BYTE;
    frame_end = 1'b0;
    case (state)
      IDLE:        load = bus.start;
      GAP:         load = bus.continuous && gap_last;
      SEND_PREFIX: begin
        load      = tx_ready;
        load_byte = pay_byte;
      end
      SEND_DATA: begin
        if (!idx_last) begin
          load      = tx_ready;
          load_byte = pay_byte;
        end else begin
`ifdef ROW_STREAM_CHECKSUM_EN
          load      = tx_ready;
          load_byte = csum;
`else
          frame_end = tx_ready;
`endif
        end
      end
`ifdef ROW_STREAM_CHECKSUM_EN
      SEND_CSUM:   frame_end = tx_ready;
`endif
      default: ;
    endcase
    if (reset) begin
      load      = 1'b0;
      frame_end = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      gap_cnt <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef ROW_STREAM_CHECKSUM_EN
      csum    <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (load) begin
            shadow  <= bus.data_in;
            state   <= SEND_PREFIX;
            busy_r  <= 1'b1;
            idx     <= '0;
            gap_cnt <= '0;
`ifdef ROW_STREAM_CHECKSUM_EN
            csum    <= PREFIX_BYTE;
`endif
          end else if (state == GAP) begin
            if (!bus.continuous) begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        SEND_PREFIX: begin
          if (load) begin
            state <= SEND_DATA;
            idx   <= '0;
`ifdef ROW_STREAM_CHECKSUM_EN
            csum  <= csum + load_byte;
`endif
          end
        end
        SEND_DATA: begin
          if (load && !idx_last) begin
            idx  <= idx + 1'b1;
`ifdef ROW_STREAM_CHECKSUM_EN
            csum <= csum + load_byte;
`endif
          end
`ifdef ROW_STREAM_CHECKSUM_EN
          else if (load) begin
            state <= SEND_CSUM;
          end
`endif
        end
        default: ;
      endcase
      // Frame completion overrides the per-state updates above.
      if (frame_end) begin
        done_r  <= 1'b1;
        gap_cnt <= '0;
        if (bus.continuous) begin
          state  <= GAP;
          busy_r <= 1'b1;
        end else begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      end
    end
  end

  row_stream_uart_tx #(
    .TICKS_PER_BIT(UART_TICKS_PER_BIT)
  ) u_uart (
    .clk_in (clk_in),
    .reset  (reset),
    .byte_in(load_byte),
    .valid  (load),
    .ready  (tx_ready),
    .tx     (tx_line)
  );

  assign bus.tx_out = tx_line;
  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
endmodule
